// File: rtl/conv_output_collector.sv
// Rebuilds raster position of adder-tree results, applies optional ReLU and writes the output buffer.
// Writes are registered one cycle after pixel_rdy; frame_done pulses one cycle after the final write.
module conv_output_collector #(
  parameter int OUT_WIDTH   = 22,
  parameter int OUT_HEIGHT  = 22,
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 10,
  parameter int COORD_WIDTH = 5,
  parameter bit RELU_EN     = 1'b1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   arm,
  input  logic                   pixel_rdy,
  input  logic [DATA_WIDTH-1:0]  pixel_data,
  output logic                   wr_en,
  output logic [ADDR_WIDTH-1:0]  wr_addr,
  output logic [DATA_WIDTH-1:0]  wr_data,
  output logic [COORD_WIDTH-1:0] x_coord,
  output logic [COORD_WIDTH-1:0] y_coord,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   err_unexpected
);

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  localparam logic [COORD_WIDTH-1:0] X_MAX = COORD_WIDTH'(OUT_WIDTH - 1);
  localparam logic [COORD_WIDTH-1:0] Y_MAX = COORD_WIDTH'(OUT_HEIGHT - 1);

  state_t                 state;
  logic [ADDR_WIDTH-1:0]  addr;
  logic [COORD_WIDTH-1:0] base_x;
  logic [COORD_WIDTH-1:0] base_y;
  logic [ADDR_WIDTH-1:0]  base_addr;
  logic                   take;
  logic                   last;
  logic [DATA_WIDTH-1:0]  relu_data;

  // An arm restarts the raster, so a coincident pixel is treated as (0,0).
  always_comb begin
    base_x    = arm ? '0 : x_coord;
    base_y    = arm ? '0 : y_coord;
    base_addr = arm ? '0 : addr;
    take      = pixel_rdy && (arm || (state == COLLECT));
    last      = (base_x == X_MAX) && (base_y == Y_MAX);
    relu_data = (RELU_EN && pixel_data[DATA_WIDTH-1]) ? '0 : pixel_data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      addr           <= '0;
      x_coord        <= '0;
      y_coord        <= '0;
      wr_en          <= 1'b0;
      wr_addr        <= '0;
      wr_data        <= '0;
      busy           <= 1'b0;
      frame_done     <= 1'b0;
      err_unexpected <= 1'b0;
    end else begin
      wr_en      <= take;
      frame_done <= (state == DONE);
      if (take) begin
        wr_addr <= base_addr;
        wr_data <= relu_data;
      end

      if (arm)
        err_unexpected <= 1'b0;
      else if (pixel_rdy && (state != COLLECT))
        err_unexpected <= 1'b1;

      if (take && last) begin
        x_coord <= '0;
        y_coord <= '0;
        addr    <= '0;
        state   <= DONE;
        busy    <= 1'b0;
      end else if (take) begin
        if (base_x == X_MAX) begin
          x_coord <= '0;
          y_coord <= base_y + 1'b1;
        end else begin
          x_coord <= base_x + 1'b1;
          y_coord <= base_y;
        end
        addr  <= base_addr + 1'b1;
        state <= COLLECT;
        busy  <= 1'b1;
      end else if (arm) begin
        x_coord <= '0;
        y_coord <= '0;
        addr    <= '0;
        state   <= COLLECT;
        busy    <= 1'b1;
      end else if (state == DONE) begin
        state <= IDLE;
        busy  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv_output_collector.sv
// Drives a ReLU and a pass-through collector with the same stream and checks both against a frame-level model.
module tb_conv_output_collector;

  localparam int W = 22;
  localparam int H = 22;
  localparam int N = W * H;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        arm = 1'b0;
  logic        pixel_rdy = 1'b0;
  logic [15:0] pixel_data = '0;

  logic        we1, we0, busy1, busy0, fd1, fd0, err1, err0;
  logic [9:0]  wa1, wa0;
  logic [15:0] wd1, wd0;
  logic [4:0]  x1, x0, y1, y0;

  conv_output_collector #(.RELU_EN(1'b1)) dut_relu (
    .clock(clock), .reset(reset), .arm(arm), .pixel_rdy(pixel_rdy), .pixel_data(pixel_data),
    .wr_en(we1), .wr_addr(wa1), .wr_data(wd1), .x_coord(x1), .y_coord(y1),
    .busy(busy1), .frame_done(fd1), .err_unexpected(err1)
  );

  conv_output_collector #(.RELU_EN(1'b0)) dut_pass (
    .clock(clock), .reset(reset), .arm(arm), .pixel_rdy(pixel_rdy), .pixel_data(pixel_data),
    .wr_en(we0), .wr_addr(wa0), .wr_data(wd0), .x_coord(x0), .y_coord(y0),
    .busy(busy0), .frame_done(fd0), .err_unexpected(err0)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // Frame-level model: pixels accepted so far in the current frame, plus held write values.
  bit          m_coll, m_done_pend, m_err, e_we, e_done;
  int          m_n, e_addr, obs_done;
  logic [15:0] e_d1, e_d0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_coll = 0; m_done_pend = 0; m_err = 0; e_we = 0; e_done = 0;
    m_n = 0; e_addr = 0; e_d1 = '0; e_d0 = '0;
  endtask

  task automatic check_all();
    chk("wr_en_relu", {31'd0, we1}, {31'd0, e_we});
    chk("wr_en_pass", {31'd0, we0}, {31'd0, e_we});
    chk("wr_addr_relu", {22'd0, wa1}, e_addr);
    chk("wr_addr_pass", {22'd0, wa0}, e_addr);
    chk("wr_data_relu", {16'd0, wd1}, {16'd0, e_d1});
    chk("wr_data_pass", {16'd0, wd0}, {16'd0, e_d0});
    chk("x_coord", {27'd0, x1}, m_n % W);
    chk("y_coord", {27'd0, y1}, m_n / W);
    chk("x_coord_pass", {27'd0, x0}, m_n % W);
    chk("y_coord_pass", {27'd0, y0}, m_n / W);
    chk("busy", {30'd0, busy1, busy0}, {30'd0, m_coll, m_coll});
    chk("frame_done", {30'd0, fd1, fd0}, {30'd0, e_done, e_done});
    chk("err_unexpected", {30'd0, err1, err0}, {30'd0, m_err, m_err});
  endtask

  // Entered and left at a falling edge.
  task automatic step(input bit a, input bit r, input logic [15:0] d);
    arm = a; pixel_rdy = r; pixel_data = d;
    @(posedge clock);
    e_done = m_done_pend;
    m_done_pend = 0;
    e_we = r && (a || m_coll);
    if (a) begin
      m_n = 0; m_coll = 1; m_err = 0;
    end
    if (e_we) begin
      e_addr = m_n;
      e_d0   = d;
      e_d1   = ($signed(d) < 0) ? 16'd0 : d;
      m_n++;
      if (m_n == N) begin
        m_n = 0; m_coll = 0; m_done_pend = 1;
      end
    end else if (r) begin
      m_err = 1;
    end
    @(negedge clock);
    arm = 0; pixel_rdy = 0;
    if (fd1) obs_done++;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_all();
    reset = 1'b1;
    idle(2);

    // Full frame back-to-back, data = index.
    obs_done = 0;
    step(1, 0, '0);
    for (int i = 0; i < N; i++) step(0, 1, 16'(i));
    chk("last_addr", {22'd0, wa0}, 483);
    idle(3);
    chk("done_count_full", obs_done, 1);

    // ReLU against pass-through.
    step(1, 0, '0);
    step(0, 1, 16'hFFFB);
    chk("relu_neg", {16'd0, wd1}, 0);
    chk("pass_neg", {16'd0, wd0}, 32'hFFFB);
    step(0, 1, 16'd7);
    chk("relu_pos", {16'd0, wd1}, 7);
    chk("pass_pos", {16'd0, wd0}, 7);

    // Gapped random frame; the arm aborts the partial frame above.
    obs_done = 0;
    step(1, 0, '0);
    for (int i = 0; i < N; i++) begin
      idle($urandom_range(3, 0));
      step(0, 1, 16'($urandom));
      if (i == 22) begin
        chk("wrap_x", {27'd0, x1}, 1);
        chk("wrap_y", {27'd0, y1}, 1);
      end
    end
    idle(3);
    chk("done_count_gapped", obs_done, 1);

    // Pixel with no frame open.
    step(0, 1, 16'h1234);
    chk("unexp_no_write", {31'd0, we1}, 0);
    chk("unexp_err", {31'd0, err1}, 1);
    idle(3);
    chk("unexp_err_held", {31'd0, err1}, 1);
    step(1, 0, '0);
    chk("unexp_err_cleared", {31'd0, err1}, 0);

    // Re-arm mid-frame with a coincident pixel.
    obs_done = 0;
    for (int i = 0; i < 100; i++) step(0, 1, 16'($urandom));
    step(1, 1, 16'hAAAA);
    chk("rearm_addr", {22'd0, wa0}, 0);
    chk("rearm_data_pass", {16'd0, wd0}, 32'hAAAA);
    chk("rearm_no_done", obs_done, 0);
    for (int i = 0; i < N - 1; i++) step(0, 1, 16'($urandom));
    idle(3);
    chk("done_count_rearm", obs_done, 1);

    // Asynchronous reset mid-frame.
    step(1, 0, '0);
    for (int i = 0; i < 200; i++) step(0, 1, 16'($urandom));
    #2 reset = 1'b0;
    #1 model_reset();
    check_all();
    @(negedge clock);
    check_all();
    reset = 1'b1;
    idle(2);

    obs_done = 0;
    step(1, 0, '0);
    for (int i = 0; i < N; i++) step(0, 1, 16'(i));
    chk("post_reset_last_addr", {22'd0, wa0}, 483);
    idle(3);
    chk("done_count_post_reset", obs_done, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
